// File: rtl/pc_fetch_unit.sv
// Architectural PC plus instruction fetch sequencer. At most one imem request
// is outstanding. Responses that belong to a redirected-away path are drained.
module pc_fetch_unit #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [31:0]      dec_instr,
  output logic [WIDTH-1:0] dec_pc
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] pc_next;
  logic             imem_req_next;
  logic [WIDTH-1:0] imem_addr_next;
  logic             dec_valid_next;
  logic [31:0]      dec_instr_next;
  logic [WIDTH-1:0] dec_pc_next;

  logic [WIDTH-1:0] redirect_target;
  logic             buf_pop;
  logic             fetch_accept;

  assign redirect_target = redirect_pc & ALIGN_MASK;
  assign buf_pop         = dec_valid & dec_ready;
  assign fetch_accept    = imem_req & imem_gnt;

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    dec_valid_next = dec_valid & ~buf_pop;
    dec_instr_next = dec_instr;
    dec_pc_next    = dec_pc;

    unique case (state_reg)
      ST_IDLE: begin
        state_next = ST_FETCH;
      end

      ST_FETCH: begin
        if (redirect_i) begin
          pc_next        = redirect_target;
          dec_valid_next = 1'b0;
          // A request granted on the redirect cycle still owes a response.
          if (fetch_accept) begin
            state_next = ST_DRAIN;
          end
        end else if (fetch_accept) begin
          state_next = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (redirect_i) begin
          pc_next        = redirect_target;
          dec_valid_next = 1'b0;
          state_next     = imem_rvalid ? ST_FETCH : ST_DRAIN;
        end else if (imem_rvalid) begin
          dec_valid_next = 1'b1;
          dec_instr_next = imem_rdata;
          dec_pc_next    = pc_reg;
          pc_next        = pc_reg + PC_STEP;
          state_next     = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        if (redirect_i) begin
          pc_next        = redirect_target;
          dec_valid_next = 1'b0;
        end
        if (imem_rvalid) begin
          state_next = ST_FETCH;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Request only into an empty buffer so a response always has a slot.
    imem_req_next  = (state_next == ST_FETCH) & ~dec_valid_next;
    imem_addr_next = pc_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      pc_reg    <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      dec_valid <= 1'b0;
      dec_instr <= '0;
      dec_pc    <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      imem_req  <= imem_req_next;
      imem_addr <= imem_addr_next;
      dec_valid <= dec_valid_next;
      dec_instr <= dec_instr_next;
      dec_pc    <= dec_pc_next;
    end
  end

endmodule
